// File: rtl/hazard_pkg.sv
// Shared constants and elaboration helpers for the
// scoreboard-based pipeline hazard unit.
package hazard_pkg;

  localparam int FWD_REG  = 0;
  localparam int NSTG_MIN = 2;
  localparam int NSTG_MAX = 6;

  function automatic int fwd_sel_w(input int nstg);
    return $clog2(nstg + 1);
  endfunction

  function automatic bit nstg_legal(input int nstg);
    return (nstg >= NSTG_MIN) && (nstg <= NSTG_MAX);
  endfunction

  function automatic bit load_rdy_legal(input int lr,
                                        input int nstg);
    return (lr >= 2) && (lr <= nstg);
  endfunction

endpackage

// File: rtl/hazard_track_stage.sv
// One scoreboard slot: {v, rd, we, ld} of the instruction
// occupying a post-decode stage; holds while frozen.
module hazard_track_stage
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              v_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              we_i,
  input  logic              ld_i,
  output logic              v_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              we_o,
  output logic              ld_o
);

  logic              v_q, v_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic              ld_q, ld_d;

  always_comb begin
    v_d  = v_q;
    rd_d = rd_q;
    we_d = we_q;
    ld_d = ld_q;
    if (!hold) begin
      v_d  = v_i;
      rd_d = rd_i;
      we_d = we_i;
      ld_d = ld_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      rd_q <= '0;
      we_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      v_q  <= v_d;
      rd_q <= rd_d;
      we_q <= we_d;
      ld_q <= ld_d;
    end
  end

  assign v_o  = v_q;
  assign rd_o = rd_q;
  assign we_o = we_q;
  assign ld_o = ld_q;

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard hazard controller: forwarding selects, load-use
// stalls, redirect flushes and performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NSTG     = 2,
  parameter int LOAD_RDY = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32,
  parameter int FSW      = fwd_sel_w(NSTG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              redirect,
  input  logic              freeze,
  output logic              stall,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic              fwd_id_rs1,
  output logic              fwd_id_rs2,
  output logic [FSW-1:0]    fwd_ex_rs1_sel,
  output logic [FSW-1:0]    fwd_ex_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (!nstg_legal(NSTG)) begin : g_bad_nstg
    $error("hazard_unit: NSTG must be 2..6");
  end
  if (!load_rdy_legal(LOAD_RDY, NSTG)) begin : g_bad_lr
    $error("hazard_unit: LOAD_RDY must be 2..NSTG");
  end

  logic [NSTG:1]     t_v, t_we, t_ld;
  logic [REG_AW-1:0] t_rd [1:NSTG];

  logic redir, id_go, ld_hz, ld_stall;

  for (genvar k = 1; k <= NSTG; k++) begin : g_trk
    logic              v_i, we_i, ld_i;
    logic [REG_AW-1:0] rd_i;
    if (k == 1) begin : g_head
      assign v_i  = id_go;
      assign rd_i = id_rd;
      assign we_i = id_rd_we;
      assign ld_i = id_is_load;
    end else begin : g_body
      assign v_i  = t_v[k-1];
      assign rd_i = t_rd[k-1];
      assign we_i = t_we[k-1];
      assign ld_i = t_ld[k-1];
    end
    hazard_track_stage #(.REG_AW(REG_AW)) u_stg (
      .clk  (clk),
      .rst  (rst),
      .hold (freeze),
      .v_i  (v_i),
      .rd_i (rd_i),
      .we_i (we_i),
      .ld_i (ld_i),
      .v_o  (t_v[k]),
      .rd_o (t_rd[k]),
      .we_o (t_we[k]),
      .ld_o (t_ld[k])
    );
  end

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             used, lu, fid;
  logic [1:0][FSW-1:0]    sel_c, sel_q, sel_d;

  assign rs   = {id_rs2, id_rs1};
  assign used = {id_rs2_used, id_rs1_used};

  // Producer at stage j reaches j+1 when the consumer enters EX.
  always_comb begin
    lu    = '0;
    fid   = '0;
    sel_c = '0;
    for (int s = 0; s < 2; s++) begin
      int j;
      j = 0;
      sel_c[s] = FSW'(FWD_REG);
      for (int k = NSTG; k >= 1; k--) begin
        if (t_v[k] && t_we[k] && (t_rd[k] == rs[s]) &&
            (rs[s] != '0) && used[s]) begin
          j = k;
        end
      end
      if (j == NSTG) begin
        fid[s] = 1'b1;
      end else if (j != 0) begin
        if (!t_ld[j] || (j + 1 >= LOAD_RDY)) begin
          sel_c[s] = FSW'(j + 1);
        end else begin
          lu[s] = 1'b1;
        end
      end
    end
  end

  assign redir    = redirect & ~freeze;
  assign ld_hz    = (|lu) & id_valid & ~redir;
  assign ld_stall = ld_hz & ~freeze;
  assign stall    = ld_hz | freeze;
  assign id_go    = id_valid & ~stall & ~redir;

  assign flush_id   = redir;
  assign bubble_ex  = redir | ld_stall;
  assign fwd_id_rs1 = fid[0];
  assign fwd_id_rs2 = fid[1];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    sel_d       = sel_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      for (int s = 0; s < 2; s++) begin
        sel_d[s] = id_go ? sel_c[s] : FSW'(FWD_REG);
      end
      stall_cnt_d = stall_cnt_q + CNT_W'(ld_stall);
      flush_cnt_d = flush_cnt_q + CNT_W'(redir);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sel_q       <= sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_ex_rs1_sel = sel_q[0];
  assign fwd_ex_rs2_sel = sel_q[1];
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: two hazard_unit configurations, directed
// scenarios plus randomized traffic against an age-based model.
module tb_hazard_unit;

  localparam int NA = 2;
  localparam int LA = 2;
  localparam int NB = 4;
  localparam int LB = 4;
  localparam int CB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] idv, u1, u2, we, ld, rdr, frz;
  logic [4:0] rs1 [2];
  logic [4:0] rs2 [2];
  logic [4:0] rd  [2];

  wire [1:0]  st, fl, bb, f1, f2;
  wire [1:0]  sa1, sa2;
  wire [2:0]  sb1, sb2;
  wire [31:0] sca, fca;
  wire [3:0]  scb, fcb;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.NSTG(NA), .LOAD_RDY(LA)) u_a (
    .clk(clk), .rst(rst), .id_valid(idv[0]),
    .id_rs1(rs1[0]), .id_rs2(rs2[0]),
    .id_rs1_used(u1[0]), .id_rs2_used(u2[0]),
    .id_rd(rd[0]), .id_rd_we(we[0]), .id_is_load(ld[0]),
    .redirect(rdr[0]), .freeze(frz[0]),
    .stall(st[0]), .flush_id(fl[0]), .bubble_ex(bb[0]),
    .fwd_id_rs1(f1[0]), .fwd_id_rs2(f2[0]),
    .fwd_ex_rs1_sel(sa1), .fwd_ex_rs2_sel(sa2),
    .stall_cnt(sca), .flush_cnt(fca)
  );

  hazard_unit #(.NSTG(NB), .LOAD_RDY(LB), .CNT_W(CB)) u_b (
    .clk(clk), .rst(rst), .id_valid(idv[1]),
    .id_rs1(rs1[1]), .id_rs2(rs2[1]),
    .id_rs1_used(u1[1]), .id_rs2_used(u2[1]),
    .id_rd(rd[1]), .id_rd_we(we[1]), .id_is_load(ld[1]),
    .redirect(rdr[1]), .freeze(frz[1]),
    .stall(st[1]), .flush_id(fl[1]), .bubble_ex(bb[1]),
    .fwd_id_rs1(f1[1]), .fwd_id_rs2(f2[1]),
    .fwd_ex_rs1_sel(sb1), .fwd_ex_rs2_sel(sb2),
    .stall_cnt(scb), .flush_cnt(fcb)
  );

  task automatic idle();
    idv = '0; u1 = '0; u2 = '0; we = '0; ld = '0;
    rdr = '0; frz = '0;
    for (int i = 0; i < 2; i++) begin
      rs1[i] = '0; rs2[i] = '0; rd[i] = '0;
    end
  endtask

  task automatic put(input int i, input int r1, input int r2,
                     input int d, input bit w, input bit l);
    idv[i] = 1'b1;
    rs1[i] = 5'(r1); u1[i] = 1'b1;
    rs2[i] = 5'(r2); u2[i] = 1'b1;
    rd[i] = 5'(d); we[i] = w; ld[i] = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    checks++;
    if ({st, fl, bb} !== 6'd0) begin
      errs++;
      $display("FAIL rst_ctl got=%b exp=0", {st, fl, bb});
    end
    checks++;
    if ({f1, f2, sa1, sa2, sb1, sb2} !== 14'd0) begin
      errs++;
      $display("FAIL rst_fwd got=%b exp=0",
               {f1, f2, sa1, sa2, sb1, sb2});
    end
    checks++;
    if ({sca, fca, scb, fcb} !== 72'd0) begin
      errs++;
      $display("FAIL rst_cnt got=%h exp=0", {sca, fca, scb, fcb});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_basic();
    put(0, 1, 2, 5, 1, 0);
    tick();
    put(0, 5, 1, 6, 1, 0);
    @(negedge clk);
    checks++;
    if (st[0] !== 1'b0) begin
      errs++; $display("FAIL fb_stall got=%b exp=0", st[0]);
    end
    tick();
    put(0, 5, 0, 7, 1, 0);
    @(negedge clk);
    checks++;
    if (sa1 !== 2'd2) begin
      errs++; $display("FAIL fb_sel_ex got=%0d exp=2", sa1);
    end
    checks++;
    if ({f1[0], f2[0]} !== 2'b10) begin
      errs++;
      $display("FAIL fb_fwd_id got=%b exp=10", {f1[0], f2[0]});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({sa1, sa2} !== 4'd0) begin
      errs++; $display("FAIL fb_sel_wb got=%b exp=0", {sa1, sa2});
    end
    drain();
  endtask

  task automatic test_load_use();
    logic [3:0] s0;
    s0 = scb;
    put(1, 0, 0, 3, 1, 1);
    tick();
    put(1, 3, 3, 4, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (st[1] !== (c < 2)) begin
        errs++;
        $display("FAIL lu_stall c=%0d got=%b exp=%b", c, st[1], c < 2);
      end
      checks++;
      if ({bb[1], fl[1]} !== {c < 2, 1'b0}) begin
        errs++;
        $display("FAIL lu_bub c=%0d got=%b", c, {bb[1], fl[1]});
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({sb1, sb2} !== {3'd4, 3'd4}) begin
      errs++; $display("FAIL lu_sel got=%0d,%0d exp=4,4", sb1, sb2);
    end
    checks++;
    if (scb !== 4'(s0 + 2)) begin
      errs++;
      $display("FAIL lu_cnt got=%0d exp=%0d", scb, 4'(s0 + 2));
    end
    drain();
  endtask

  task automatic test_x0();
    put(1, 1, 2, 0, 1, 1);
    put(0, 1, 2, 0, 1, 1);
    tick();
    put(1, 0, 0, 8, 1, 0);
    put(0, 0, 0, 8, 1, 0);
    @(negedge clk);
    checks++;
    if (st !== 2'b00) begin
      errs++; $display("FAIL x0_stall got=%b exp=00", st);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({f1, f2, sa1, sa2, sb1, sb2} !== 14'd0) begin
      errs++;
      $display("FAIL x0_sel got=%b exp=0", {f1, f2, sa1, sa2, sb1, sb2});
    end
    drain();
  endtask

  task automatic test_redirect();
    logic [3:0] s0, q0;
    s0 = scb; q0 = fcb;
    put(1, 0, 0, 3, 1, 1);
    tick();
    put(1, 3, 3, 4, 1, 0);
    rdr[1] = 1'b1;
    @(negedge clk);
    checks++;
    if ({fl[1], bb[1], st[1]} !== 3'b110) begin
      errs++;
      $display("FAIL rd_ctl got=%b exp=110", {fl[1], bb[1], st[1]});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({fcb, scb} !== {4'(q0 + 1), s0}) begin
      errs++;
      $display("FAIL rd_cnt got=%0d,%0d exp=%0d,%0d",
               fcb, scb, 4'(q0 + 1), s0);
    end
    checks++;
    if (sb1 !== 3'd0) begin
      errs++; $display("FAIL rd_sel got=%0d exp=0", sb1);
    end
    drain();
  endtask

  task automatic test_freeze();
    logic [3:0] s0, q0;
    s0 = scb; q0 = fcb;
    put(1, 0, 0, 3, 1, 1);
    put(0, 1, 2, 5, 1, 0);
    tick();
    put(1, 3, 3, 4, 1, 0);
    put(0, 5, 1, 6, 1, 0);
    tick();
    idv[0] = 1'b0;
    frz = 2'b11;
    for (int c = 0; c < 3; c++) begin
      rdr[1] = (c == 1);
      @(negedge clk);
      checks++;
      if ({st, bb, fl} !== 6'b110000) begin
        errs++;
        $display("FAIL fz_ctl c=%0d got=%b exp=110000", c, {st, bb, fl});
      end
      checks++;
      if ({sa1, sb1, scb} !== {2'd2, 3'd0, 4'(s0 + 1)}) begin
        errs++;
        $display("FAIL fz_hold c=%0d got=%0d,%0d,%0d", c, sa1, sb1, scb);
      end
      tick();
    end
    frz = '0;
    rdr = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (st[1] !== (c == 0)) begin
        errs++;
        $display("FAIL fz_rel c=%0d got=%b exp=%b", c, st[1], c == 0);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({sb1, sb2, scb, fcb} !== {3'd4, 3'd4, 4'(s0 + 2), q0}) begin
      errs++;
      $display("FAIL fz_end got=%0d,%0d,%0d,%0d", sb1, sb2, scb, fcb);
    end
    drain();
  endtask

  task automatic test_async_reset();
    put(1, 0, 0, 3, 1, 1);
    tick();
    put(1, 3, 3, 4, 1, 0);
    #2;
    checks++;
    if (st[1] !== 1'b1) begin
      errs++; $display("FAIL ar_pre got=%b exp=1", st[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({st[1], bb[1], sb1, sb2} !== 8'd0) begin
      errs++;
      $display("FAIL ar_out got=%b exp=0", {st[1], bb[1], sb1, sb2});
    end
    checks++;
    if ({sca, fca, scb, fcb} !== 72'd0) begin
      errs++; $display("FAIL ar_cnt got=%h exp=0", {sca, fca, scb, fcb});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st[1] !== 1'b0) begin
      errs++; $display("FAIL ar_first got=%b exp=0", st[1]);
    end
    drain();
    put(1, 0, 0, 3, 1, 1);
    tick();
    put(1, 3, 3, 4, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (st[1] !== (c < 2)) begin
        errs++;
        $display("FAIL ar_stall c=%0d got=%b exp=%b", c, st[1], c < 2);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({sb1, sb2, scb} !== {3'd4, 3'd4, 4'd2}) begin
      errs++; $display("FAIL ar_end got=%0d,%0d,%0d", sb1, sb2, scb);
    end
    drain();
  endtask

  // Model: in-flight instructions tagged with their age (stage).
  typedef struct {
    int inst;
    int age;
    int rd;
    bit we;
    bit ld;
  } fl_t;

  fl_t q[$];
  int  ns [2] = '{NA, NB};
  int  lr [2] = '{LA, LB};
  int  msel [2][2];
  int  mst [2];
  int  mfl [2];

  function automatic void youngest(input int i, input int rs,
                                   input bit used, output int age,
                                   output bit isl);
    age = 0;
    isl = 1'b0;
    if (!used || rs == 0) return;
    foreach (q[e]) begin
      if (q[e].inst == i && q[e].we && q[e].rd == rs &&
          (age == 0 || q[e].age < age)) begin
        age = q[e].age;
        isl = q[e].ld;
      end
    end
  endfunction

  task automatic test_random();
    bit hold [2] = '{1'b0, 1'b0};
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      msel[i][0] = 0; msel[i][1] = 0; mst[i] = 0; mfl[i] = 0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          idv[i] = ($urandom_range(0, 9) < 8);
          rs1[i] = 5'($urandom_range(0, 3));
          rs2[i] = 5'($urandom_range(0, 3));
          u1[i] = ($urandom_range(0, 3) != 0);
          u2[i] = ($urandom_range(0, 3) != 0);
          rd[i] = 5'($urandom_range(0, 3));
          we[i] = ($urandom_range(0, 4) != 0);
          ld[i] = ($urandom_range(0, 2) == 0);
        end
        rdr[i] = ($urandom_range(0, 9) == 0);
        frz[i] = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int  es [2];
        bit  efid [2];
        bit  elu [2];
        bit  r, hz, est, issue;
        int  gs1, gs2, cm, fm;
        logic [31:0] gsc, gfc;
        for (int s = 0; s < 2; s++) begin
          int a;
          bit l;
          youngest(i, s ? int'(rs2[i]) : int'(rs1[i]),
                   s ? u2[i] : u1[i], a, l);
          es[s] = 0;
          efid[s] = (a == ns[i]);
          elu[s] = 1'b0;
          if (a != 0 && a < ns[i]) begin
            if (!l || a + 1 >= lr[i]) es[s] = a + 1;
            else elu[s] = 1'b1;
          end
        end
        r = rdr[i] && !frz[i];
        hz = (elu[0] || elu[1]) && idv[i] && !r;
        est = hz || frz[i];
        issue = idv[i] && !est && !r;
        gs1 = i ? int'(sb1) : int'(sa1);
        gs2 = i ? int'(sb2) : int'(sa2);
        gsc = i ? 32'(scb) : sca;
        gfc = i ? 32'(fcb) : fca;
        cm = i ? (mst[i] & 15) : mst[i];
        fm = i ? (mfl[i] & 15) : mfl[i];
        checks++;
        if ({st[i], fl[i], bb[i]} !== {est, r, r || (hz && !frz[i])}) begin
          errs++;
          $display("FAIL rnd_ctl i=%0d cyc=%0d got=%b exp=%b", i, cyc,
                   {st[i], fl[i], bb[i]}, {est, r, r || (hz && !frz[i])});
        end
        checks++;
        if ({f1[i], f2[i]} !== {efid[0], efid[1]}) begin
          errs++;
          $display("FAIL rnd_fid i=%0d cyc=%0d got=%b exp=%b", i, cyc,
                   {f1[i], f2[i]}, {efid[0], efid[1]});
        end
        checks++;
        if (gs1 != msel[i][0] || gs2 != msel[i][1]) begin
          errs++;
          $display("FAIL rnd_sel i=%0d cyc=%0d got=%0d,%0d exp=%0d,%0d",
                   i, cyc, gs1, gs2, msel[i][0], msel[i][1]);
        end
        checks++;
        if (gsc !== 32'(cm) || gfc !== 32'(fm)) begin
          errs++;
          $display("FAIL rnd_cnt i=%0d cyc=%0d got=%0d,%0d exp=%0d,%0d",
                   i, cyc, gsc, gfc, cm, fm);
        end
        if (!frz[i]) begin
          msel[i][0] = issue ? es[0] : 0;
          msel[i][1] = issue ? es[1] : 0;
          mst[i] += int'(hz);
          mfl[i] += int'(r);
          for (int e = q.size() - 1; e >= 0; e--) begin
            if (q[e].inst == i) begin
              q[e].age = q[e].age + 1;
              if (q[e].age > ns[i]) q.delete(e);
            end
          end
          if (issue) q.push_back('{i, 1, int'(rd[i]), we[i], ld[i]});
        end
        hold[i] = est;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fwd_basic();
    test_load_use();
    test_x0();
    test_redirect();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised pipeline hazard controller for the Riscv151 core family. It replaces the fixed FA_1/FB_1/FA_2/FB_2 forwarding decode with a scoreboard that tracks in-flight destinations across N post-decode stages.
- Produces decode-side and execute-side forwarding selects, load-use stalls, redirect flushes and performance counters.
- Sits beside the controller, between decode and the datapath bypass muxes.

Parameters:
- NSTG, 2, number of stages after ID. Stage 1 = EX, stage NSTG = WB, which writes the reg_file at the end of its cycle. Legal range 2..6.
- LOAD_RDY, 2, first stage at which a load result is forwardable. Legal range 2..NSTG.
- REG_AW, 5, register address width.
- CNT_W, 32, performance counter width.
- FSW, $clog2(NSTG+1), forward-select width. Derived; do not override.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_AW  source 1 address
- id_rs2  in  REG_AW  source 2 address
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_AW  destination address
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- redirect  in  1  EX resolved a taken branch or jump this cycle
- freeze  in  1  external hold of the whole pipeline (MMIO/UART wait)
- stall  out  1  hold PC and IF/ID; combinational
- flush_id  out  1  replace the ID instruction with a nop (InstSel); combinational
- bubble_ex  out  1  EX gets a nop next cycle; combinational
- fwd_id_rs1  out  1  select the WB result bus in place of rd1 at ID; combinational
- fwd_id_rs2  out  1  select the WB result bus in place of rd2 at ID; combinational
- fwd_ex_rs1_sel  out  FSW  EX operand A source: 0 = registered operand, k = stage-k result bus; registered
- fwd_ex_rs2_sel  out  FSW  EX operand B source, same encoding; registered
- stall_cnt  out  CNT_W  cycles with a load-use stall asserted
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (async): all tracker valid bits = 0. fwd_ex_*_sel = 0. Counters = 0. Combinational outputs then evaluate to 0.
- Tracker: per stage k in 1..NSTG, hold {v, rd, we, ld}.
  - Each cycle with freeze=0: stage k+1 <= stage k.
  - Stage 1 <= ID info if id_valid & !stall & !redirect; otherwise v=0.
  - freeze=1: tracker, fwd_ex_*_sel and counters hold.
- Match(k, rs): v & we & rd==rs & rs!=0 & rs_used. Only the youngest match (lowest k) counts.
- fwd_id_rsX = 1 when the youngest match is stage NSTG.
- EX select, computed in ID for a youngest match at stage j < NSTG:
  - Forward from j+1 when !ld or j+1 >= LOAD_RDY.
  - Otherwise it is a load-use hazard.
- stall = load-use hazard on either source & id_valid & !redirect, OR freeze.
- redirect=1: flush_id=1 and bubble_ex=1. Redirect has priority over a load-use stall in the same cycle. Redirect is ignored while freeze=1; the source must hold it.
- bubble_ex = redirect | (stall & !freeze).
- fwd_ex_*_sel register: captures the computed value when ID advances; forced to 0 on bubble.
- Counters:
  - stall_cnt +1 per cycle with a load-use stall (freeze excluded).
  - flush_cnt +1 per redirect cycle.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation clears all in-flight state immediately. The first post-reset instruction sees no hazards.

Decomposition:
- Package hazard_pkg:
  - FWD_REG = 0.
  - Legality checks for NSTG and LOAD_RDY.
  - Helper function fwd_sel_w(NSTG).
- One sub-module, hazard_track_stage: per-stage {v, rd, we, ld} register with hold/clear. Instantiate it NSTG times via generate.
- The youngest-match priority encoder stays in hazard_unit.

Test Plan:
- NSTG=2, LOAD_RDY=2: "add x5" then "sub x6,x5,x1" back-to-back -> fwd_ex_rs1_sel=2 in the sub's EX cycle, stall=0. Then "or x7,x5,x0" two cycles later -> fwd_id_rs1=1.
- NSTG=4, LOAD_RDY=4: "lw x3" then "add x4,x3,x3" -> stall=1 for 2 cycles, stall_cnt=2, then fwd_ex_rs1_sel=fwd_ex_rs2_sel=4.
- Writer to x0 followed by a reader of x0 -> no stall; all selects 0.
- Load-use stall cycle with redirect=1 -> flush_id=1, bubble_ex=1, stall=0, flush_cnt+1, stall_cnt unchanged.
- freeze=1 for 3 cycles during a pending forward -> stall=1, tracker and selects unchanged. After release the forward resolves exactly as without the freeze.
- rst asserted asynchronously mid-stall -> outputs 0 immediately; counters 0; the next "lw x3; add x4,x3" pair behaves as from cold start.
